code_lock_ctrl: RTL and testbench

Parametrised keypad-lock controller that generalises the board's 4-digit lock. Its features:
- Code length is set by a parameter.
- Digits are entered serially from the 4-bit switch bank.
- Retries are bounded, with a timed lockout after too many failures.
- One-cycle unlock and fail strobes are provided.

It sits between the debounced front-panel buttons and the seven-segment display path, and runs on the divided slow clock.

---
 rtl/code_lock_ctrl.sv | 170 +++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: parametrised keypad-lock controller.
// Digits arrive serially on `switch` with an `enter` strobe. INIT stores
// a master code, LOCKED checks full-length entries against it, UNLOCKED
// waits to relock or rearm, and LOCKOUT is a timed penalty after
// MAX_TRIES wrong codes. Every output is registered.
module code_lock_ctrl #(
  parameter int DIGITS         = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             master_rst,
  input  logic                             enter,
  input  logic [3:0]                       switch,
  input  logic                             clear,
  input  logic                             set_button,
  input  logic                             change,
  output logic [4*DIGITS-1:0]              entry,
  output logic [$clog2(DIGITS+1)-1:0]      digit_count,
  output logic [1:0]                       status,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic                             unlock_pulse,
  output logic                             fail_pulse
);

  localparam int ENTRY_W = 4 * DIGITS;
  localparam int CNT_W   = $clog2(DIGITS + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int LOCK_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DIGITS);
  localparam logic [TRY_W-1:0]  TRIES_MAX  = TRY_W'(MAX_TRIES);
  localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCKOUT_CYCLES - 1);

  // Encodings double as the externally visible status code.
  typedef enum logic [1:0] {
    ST_INIT     = 2'b00,
    ST_LOCKED   = 2'b01,
    ST_UNLOCKED = 2'b10,
    ST_LOCKOUT  = 2'b11
  } state_t;

  state_t              state, state_nxt;
  logic [ENTRY_W-1:0]  master, master_nxt;
  logic [ENTRY_W-1:0]  entry_nxt, edit_entry;
  logic [CNT_W-1:0]    count_nxt, edit_count;
  logic [TRY_W-1:0]    tries_nxt;
  logic [LOCK_W-1:0]   lock_cnt, lock_nxt;
  logic                unlock_nxt, fail_nxt;
  logic                full;

  assign full   = (digit_count == FULL_COUNT);
  assign status = state;

  // Ordinary keypad editing: clear beats enter, and a full entry ignores enter.
  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    edit_entry = entry;
    edit_count = digit_count;
    if (clear) begin
      edit_entry = '0;
      edit_count = '0;
    end else if (enter && !full) begin
      // A shift keeps this legal for DIGITS == 1, where a part-select would be empty.
      edit_entry = (entry << 4) | ENTRY_W'(switch);
      edit_count = digit_count + CNT_W'(1);
    end
  end

  // Next-state and next-output decisions for the lock sequencer.
  always_comb begin
    state_nxt  = state;
    entry_nxt  = edit_entry;
    count_nxt  = edit_count;
    master_nxt = master;
    tries_nxt  = tries_left;
    lock_nxt   = lock_cnt;
    unlock_nxt = 1'b0;
    fail_nxt   = 1'b0;

    case (state)
      ST_INIT: begin
        if (set_button && full) begin
          master_nxt = entry;
          entry_nxt  = '0;
          count_nxt  = '0;
          tries_nxt  = TRIES_MAX;
          state_nxt  = ST_LOCKED;
        end
      end

      ST_LOCKED: begin
        // A full entry is judged on the following edge; clear/enter are moot then.
        if (full) begin
          entry_nxt = '0;
          count_nxt = '0;
          if (entry == master) begin
            unlock_nxt = 1'b1;
            tries_nxt  = TRIES_MAX;
            state_nxt  = ST_UNLOCKED;
          end else begin
            fail_nxt = 1'b1;
            // The <= guard keeps tries_left from wrapping even if it were already 0.
            if (tries_left <= TRY_W'(1)) begin
              tries_nxt = '0;
              lock_nxt  = LOCK_LOAD;
              state_nxt = ST_LOCKOUT;
            end else begin
              tries_nxt = tries_left - TRY_W'(1);
            end
          end
        end
      end

      ST_UNLOCKED: begin
        if (change) begin
          entry_nxt = '0;
          count_nxt = '0;
          state_nxt = ST_INIT;
        end else if (set_button) begin
          entry_nxt = '0;
          count_nxt = '0;
          tries_nxt = TRIES_MAX;
          state_nxt = ST_LOCKED;
        end
      end

      ST_LOCKOUT: begin
        // Keypad is dead here; the counter was loaded with LOCKOUT_CYCLES-1 so
        // the exit edge lands exactly LOCKOUT_CYCLES edges after entry.
        entry_nxt = '0;
        count_nxt = '0;
        if (lock_cnt == '0) begin
          tries_nxt = TRIES_MAX;
          state_nxt = ST_LOCKED;
        end else begin
          lock_nxt = lock_cnt - LOCK_W'(1);
        end
      end

      default: state_nxt = ST_INIT;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!master_rst) begin
      state        <= ST_INIT;
      entry        <= '0;
      digit_count  <= '0;
      // NOTE: the stored master code is a plain register and is reset to 0 like the rest.
      master       <= '0;
      tries_left   <= TRIES_MAX;
      lock_cnt     <= '0;
      unlock_pulse <= 1'b0;
      fail_pulse   <= 1'b0;
    end else begin
      state        <= state_nxt;
      entry        <= entry_nxt;
      digit_count  <= count_nxt;
      master       <= master_nxt;
      tries_left   <= tries_nxt;
      lock_cnt     <= lock_nxt;
      unlock_pulse <= unlock_nxt;
      fail_pulse   <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl: directed scenarios followed by
// random keypad traffic, all compared against a queue-based reference model.
module tb_code_lock_ctrl;

  localparam int DIGITS         = 4;
  localparam int MAX_TRIES      = 3;
  localparam int LOCKOUT_CYCLES = 8;

  logic        clk = 1'b0;
  logic        master_rst, enter, clear, set_button, change;
  logic [3:0]  switch;
  logic [4*DIGITS-1:0]            entry;
  logic [$clog2(DIGITS+1)-1:0]    digit_count;
  logic [1:0]                     status;
  logic [$clog2(MAX_TRIES+1)-1:0] tries_left;
  logic                           unlock_pulse, fail_pulse;

  always #5 clk = ~clk;

  code_lock_ctrl #(
    .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .master_rst(master_rst), .enter(enter), .switch(switch),
    .clear(clear), .set_button(set_button), .change(change),
    .entry(entry), .digit_count(digit_count), .status(status),
    .tries_left(tries_left), .unlock_pulse(unlock_pulse), .fail_pulse(fail_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode holds the status code, digits are kept as a queue,
  // lockout is tracked as the number of edges still to spend there.
  int          m_mode;
  int          m_digits[$];
  logic [31:0] m_master;
  int          m_tries;
  int          m_rem;
  bit          m_unlock, m_fail;

  function automatic logic [31:0] m_value();
    logic [31:0] v = 0;
    foreach (m_digits[i]) v = (v << 4) | m_digits[i];
    return v;
  endfunction

  task automatic m_edit(input bit en, input logic [3:0] sw, input bit clr);
    if (clr) m_digits.delete();
    else if (en && m_digits.size() < DIGITS) m_digits.push_back(int'(sw));
  endtask

  task automatic model_step(input bit rst_n, input bit en, input logic [3:0] sw,
                            input bit clr, input bit st, input bit chg);
    m_unlock = 0;
    m_fail   = 0;
    if (!rst_n) begin
      m_mode = 0; m_digits.delete(); m_master = 0; m_tries = MAX_TRIES; m_rem = 0;
      return;
    end
    case (m_mode)
      0: if (st && m_digits.size() == DIGITS) begin
           m_master = m_value(); m_digits.delete(); m_tries = MAX_TRIES; m_mode = 1;
         end else m_edit(en, sw, clr);
      1: if (m_digits.size() == DIGITS) begin
           logic [31:0] code = m_value();
           m_digits.delete();
           if (code == m_master) begin
             m_unlock = 1; m_tries = MAX_TRIES; m_mode = 2;
           end else begin
             m_fail = 1;
             m_tries--;
             if (m_tries == 0) begin m_mode = 3; m_rem = LOCKOUT_CYCLES; end
           end
         end else m_edit(en, sw, clr);
      2: if (chg) begin m_digits.delete(); m_mode = 0; end
         else if (st) begin m_digits.delete(); m_tries = MAX_TRIES; m_mode = 1; end
         else m_edit(en, sw, clr);
      default: begin
        m_rem--;
        if (m_rem == 0) begin m_mode = 1; m_tries = MAX_TRIES; end
      end
    endcase
  endtask

  task automatic compare_all();
    check("entry", 32'(entry), m_value());
    check("digit_count", 32'(digit_count), m_digits.size());
    check("status", 32'(status), m_mode);
    check("tries_left", 32'(tries_left), m_tries);
    check("unlock_pulse", 32'(unlock_pulse), 32'(m_unlock));
    check("fail_pulse", 32'(fail_pulse), 32'(m_fail));
    check("pulse_overlap", 32'(unlock_pulse & fail_pulse), 0);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare #1 later.
  task automatic tick(input bit rst_n, input bit en, input logic [3:0] sw,
                      input bit clr, input bit st, input bit chg);
    master_rst = rst_n; enter = en; switch = sw;
    clear = clr; set_button = st; change = chg;
    @(posedge clk);
    model_step(rst_n, en, sw, clr, st, chg);
    #1;
    compare_all();
  endtask

  task automatic idle();
    tick(1, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic key(input logic [3:0] d);
    tick(1, 1, d, 0, 0, 0);
  endtask

  task automatic type_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) key(code[4*i +: 4]);
  endtask

  initial begin
    master_rst = 1'b0; enter = 1'b0; switch = '0;
    clear = 1'b0; set_button = 1'b0; change = 1'b0;
    @(negedge clk);

    // Reset state.
    tick(0, 0, 4'h0, 0, 0, 0);
    check("reset_status", 32'(status), 0);
    check("reset_tries", 32'(tries_left), MAX_TRIES);

    // Arm with 1234.
    type_code(16'h1234);
    tick(1, 0, 4'h0, 0, 1, 0);
    check("arm_status", 32'(status), 1);
    check("arm_entry", 32'(entry), 0);

    // Unlock: full code visible for one cycle, then status 10 with a pulse.
    type_code(16'h1234);
    check("unlock_entry", 32'(entry), 32'h1234);
    idle();
    check("unlock_status", 32'(status), 2);
    check("unlock_pulse_hi", 32'(unlock_pulse), 1);
    idle();
    check("unlock_pulse_lo", 32'(unlock_pulse), 0);

    // change beats set_button in UNLOCKED.
    tick(1, 0, 4'h0, 0, 1, 1);
    check("priority_status", 32'(status), 0);

    // Entry bounds in INIT.
    type_code(16'h1234);
    key(4'h5);
    check("fifth_digit", 32'(entry), 32'h1234);
    tick(1, 1, 4'h7, 1, 0, 0);
    check("clear_enter", 32'(digit_count), 0);
    key(4'h1); key(4'h2); key(4'h3);
    tick(1, 0, 4'h0, 0, 1, 0);
    check("short_set", 32'(status), 0);
    tick(1, 0, 4'h0, 1, 0, 0);

    // Re-arm, then three wrong codes into lockout; keys pressed during lockout.
    type_code(16'h1234);
    tick(1, 0, 4'h0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      type_code(16'h1235);
      tick(1, 0, 4'h0, 1, 0, 0);
      check("fail_strobe", 32'(fail_pulse), 1);
    end
    check("lockout_status", 32'(status), 3);
    for (int c = 0; c < LOCKOUT_CYCLES + 2; c++) key(4'h9);
    check("after_lockout", 32'(status), 1);

    // Second lockout aborted by reset at its third cycle.
    for (int k = 0; k < 3; k++) begin
      type_code(16'hAAAA);
      idle();
    end
    idle(); idle();
    tick(0, 1, 4'h3, 0, 0, 0);
    check("rst_lockout_status", 32'(status), 0);
    check("rst_lockout_tries", 32'(tries_left), MAX_TRIES);

    // Random traffic, biased so that LOCKED often sees the right digits.
    for (int n = 0; n < 4000; n++) begin
      bit          r_rst = ($urandom_range(0, 299) != 0);
      bit          r_en  = ($urandom_range(0, 9) < 5);
      bit          r_clr = ($urandom_range(0, 39) == 0);
      bit          r_set = ($urandom_range(0, 14) == 0);
      bit          r_chg = ($urandom_range(0, 19) == 0);
      logic [3:0]  r_sw  = 4'($urandom_range(0, 15));
      if (m_digits.size() < DIGITS && $urandom_range(0, 9) < 7)
        r_sw = 4'(m_master >> (4 * (DIGITS - 1 - m_digits.size())));
      tick(r_rst, r_en, r_sw, r_clr, r_set, r_chg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
